spi_shift: RTL
==============

// Module: spi_shift
// PURPOSE
//  Data stage of the SPI master, sitting directly downstream of spi_clkgen.
//  Takes the clock generator's edge pulses (cpol_0 = pre-rising, cpol_1 = pre-falling).
//  Serialises a parallel word onto mosi, samples miso into a parallel rx word,
//  and drives tip/last_clk back to spi_clkgen to frame the transfer.
// PARAMETERS
//  LEN_W    5    width of len; MAX_LEN = 2**LEN_W (=32) is the largest word, also the tx_data/rx_data width
// PORTS
//  wb_clk_in   in   1        system clock; all logic on its rising edge
//  wb_rst_n    in   1        synchronous, active-low reset
//  go          in   1        start request, single-cycle pulse
//  len         in   LEN_W    bit count of the transfer; 0 means MAX_LEN
//  lsb         in   1        1: bit 0 first; 0: bit N-1 first
//  tx_negedge  in   1        1: mosi updates on cpol_1; 0: on cpol_0
//  rx_negedge  in   1        1: miso sampled on cpol_1; 0: on cpol_0
//  cpol_0      in   1        pulse from spi_clkgen, next sclk edge is rising
//  cpol_1      in   1        pulse from spi_clkgen, next sclk edge is falling
//  tx_data     in   MAX_LEN  word to send; low N bits used
//  miso        in   1        serial input (already synchronised)
//  mosi        out  1        serial output
//  rx_data     out  MAX_LEN  received word, valid when done pulses
//  tip         out  1        transfer in progress
//  last_clk    out  1        final receive edge pending, to spi_clkgen
//  done        out  1        one-cycle pulse at transfer end
// BEHAVIOUR
//  Reset (wb_rst_n=0 at a clock edge):
//   - mosi, tip, last_clk, done all 0; rx_data 0; counters 0.
//   - Reset mid-transfer aborts: no done pulse, and tip is 0 the following cycle.
//  Edge select:
//   - tx_edge = tx_negedge ? cpol_1 : cpol_0
//   - rx_edge = rx_negedge ? cpol_1 : cpol_0
//   - cpol_0/cpol_1 are ignored while tip=0.
//  States: IDLE (tip=0), XFER (tip=1).
//  IDLE -> XFER on go=1:
//   - N = (len==0) ? MAX_LEN : len; tx_data latched into tx_reg.
//   - mosi <= first bit (lsb ? tx_reg[0] : tx_reg[N-1]).
//   - tx_cnt <= N-1, rx_cnt <= N; rx_data cleared to 0; tip <= 1.
//   - All of the above in the same clock edge, so mosi is valid before the first sclk edge.
//  XFER, tx_edge with tx_cnt>0:
//   - mosi <= next bit; index = lsb ? (N-tx_cnt) : (tx_cnt-1).
//   - tx_cnt <= tx_cnt-1.
//  XFER, tx_edge with tx_cnt==0: mosi holds its value.
//  XFER, rx_edge:
//   - rx_data[idx] <= miso; idx = lsb ? (N-rx_cnt) : (rx_cnt-1).
//   - rx_cnt <= rx_cnt-1.
//   - Bits >= N stay 0.
//  tx_edge and rx_edge in the same cycle are both applied; the tx and rx paths are independent.
//  last_clk = tip && rx_cnt==1 (registered, same cycle as rx_cnt update).
//   spi_clkgen then permits only the return-to-idle sclk transition.
//  XFER -> IDLE on the rx_edge that sees rx_cnt==1:
//   - Final bit captured; tip <= 0, last_clk <= 0, done <= 1 for exactly one cycle.
//   - mosi <= 0.
//  go while tip=1 is ignored, with no effect on the word or counters.
//  go in the same cycle as the ending rx_edge is ignored; a new go is accepted from the next cycle.
//  rx_data is stable from done until the next accepted go.
//  Counter widths: tx_cnt and rx_cnt are LEN_W+1 bits so that MAX_LEN is representable.
//   - No wrap; the counters are never decremented at 0.
// STRUCTURE
//  spi_pkg: constants LEN_W default, MAX_LEN, state encoding (ST_IDLE, ST_XFER).
//  One sub-module, spi_bit_cnt: loadable LEN_W+1 down-counter with dec enable and ==0/==1 flags.
//   Instantiated twice, once for tx and once for rx.
//  Bit-index muxing and the FSM stay in spi_shift.
// TESTING (bench models spi_clkgen: sclk toggles one cycle after each cpol pulse, divider=2)
//  1 MSB-first, len=8, tx_data=0xA5, tx_negedge=1, rx_negedge=0, miso fed 0x3C:
//    mosi sequence 1,0,1,0,0,1,0,1; rx_data=0x3C; one done pulse; 8 rx_edges.
//  2 LSB-first, len=8, tx_data=0xA5:
//    mosi sequence 1,0,1,0,0,1,0,1 reversed (bit0 first); miso 0x81 -> rx_data=0x81.
//  3 len=0 (32 bits), tx_data=0xDEADBEEF, loopback miso=mosi:
//    rx_data=0xDEADBEEF; last_clk high only during the final rx bit.
//  4 len=3, tx_data=0xFFFF_FFF5:
//    mosi 1,0,1; rx_data[31:3]=0 after done; go pulsed mid-transfer -> ignored, no second transfer.
//  5 wb_rst_n=0 asserted after 4 of 8 bits:
//    next cycle tip=0, mosi=0, rx_data=0, no done; a fresh go then completes normally.
//  6 tx_negedge=rx_negedge=0 (same-edge), len=4, tx_data=0x9, loopback:
//    rx_data=0x9; the tx and rx updates in one cycle do not corrupt each other.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and state encoding for the SPI data stage
//
// Purpose: default word-length parameters and the FSM state type used by
//          spi_shift and its helpers.
// Ports:   none (package).

package spi_pkg;

  // Default width of the len field; MAX_LEN is the longest word and the
  // width of the parallel tx/rx buses.
  localparam int LEN_W_DEF   = 5;
  localparam int MAX_LEN_DEF = 2 ** LEN_W_DEF;

  // IDLE carries tip=0, XFER carries tip=1.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_bit_cnt.sv
// rtl/spi_bit_cnt.sv - loadable down-counter with zero/one flags
//
// Purpose: counts remaining bits of a transfer. Load wins over decrement;
//          the count never wraps below zero.
// Ports:
//   clk      in   1   clock, rising edge
//   rst_n    in   1   synchronous active-low reset (count -> 0)
//   load     in   1   load load_val
//   load_val in   W   value to load
//   dec      in   1   decrement request (ignored when count is 0)
//   cnt      out  W   current count
//   zero     out  1   cnt == 0
//   one      out  1   cnt == 1

module spi_bit_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero,
  output logic         one
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);
  assign one  = (cnt == W'(1));

endmodule

// File: rtl/spi_shift.sv
// rtl/spi_shift.sv - SPI master data stage: serialise tx word, capture rx word
//
// Purpose: driven by the clock generator's edge pulses, shifts a parallel word
//          out on mosi, samples miso into rx_data, and frames the transfer with
//          tip/last_clk back to the clock generator.
// Ports:
//   wb_clk_in   in   1        system clock, rising edge
//   wb_rst_n    in   1        synchronous active-low reset
//   go          in   1        start pulse (accepted only while idle)
//   len         in   LEN_W    bit count, 0 means MAX_LEN
//   lsb         in   1        1: bit 0 first, 0: bit N-1 first
//   tx_negedge  in   1        mosi updates on cpol_1 (1) or cpol_0 (0)
//   rx_negedge  in   1        miso sampled on cpol_1 (1) or cpol_0 (0)
//   cpol_0      in   1        next sclk edge is rising
//   cpol_1      in   1        next sclk edge is falling
//   tx_data     in   MAX_LEN  word to send, low N bits used
//   miso        in   1        serial input
//   mosi        out  1        serial output
//   rx_data     out  MAX_LEN  received word, valid at done
//   tip         out  1        transfer in progress
//   last_clk    out  1        final receive edge pending
//   done        out  1        one-cycle end-of-transfer pulse

module spi_shift
  import spi_pkg::*;
#(
  parameter  int LEN_W   = LEN_W_DEF,
  localparam int MAX_LEN = 2 ** LEN_W,
  localparam int CNT_W   = LEN_W + 1
) (
  input  logic               wb_clk_in,
  input  logic               wb_rst_n,
  input  logic               go,
  input  logic [LEN_W-1:0]   len,
  input  logic               lsb,
  input  logic               tx_negedge,
  input  logic               rx_negedge,
  input  logic               cpol_0,
  input  logic               cpol_1,
  input  logic [MAX_LEN-1:0] tx_data,
  input  logic               miso,
  output logic               mosi,
  output logic [MAX_LEN-1:0] rx_data,
  output logic               tip,
  output logic               last_clk,
  output logic               done
);

  spi_state_t state_q, state_d;

  logic               go_ok;
  logic               finish;
  logic               tx_edge;
  logic               rx_edge;

  logic [MAX_LEN-1:0] tx_reg;
  logic [LEN_W-1:0]   len_q;
  logic               lsb_q;

  logic [CNT_W-1:0]   len_n;
  logic [LEN_W-1:0]   first_idx;
  logic [LEN_W-1:0]   tx_idx;
  logic [LEN_W-1:0]   rx_idx;

  logic [CNT_W-1:0]   tx_cnt;
  logic [CNT_W-1:0]   rx_cnt;
  logic               tx_zero;
  logic               rx_zero;
  logic               rx_one;
  logic               unused_tx_one;
  logic               unused_cnt_msb;

  // len==0 encodes MAX_LEN, which needs the extra counter bit.
  assign len_n     = (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
  // N-1 in LEN_W bits: len-1 wraps 0 to MAX_LEN-1, which is exactly right.
  assign first_idx = len - LEN_W'(1);

  // Bit indices only need LEN_W bits: N - cnt is computed modulo MAX_LEN, so
  // storing len (where 0 stands for MAX_LEN) gives the correct result.
  assign tx_idx = lsb_q ? (len_q - tx_cnt[LEN_W-1:0]) : (tx_cnt[LEN_W-1:0] - LEN_W'(1));
  assign rx_idx = lsb_q ? (len_q - rx_cnt[LEN_W-1:0]) : (rx_cnt[LEN_W-1:0] - LEN_W'(1));
  assign unused_cnt_msb = tx_cnt[LEN_W] ^ rx_cnt[LEN_W];

  assign tip      = (state_q == ST_XFER);
  assign tx_edge  = tip && (tx_negedge ? cpol_1 : cpol_0);
  assign rx_edge  = tip && (rx_negedge ? cpol_1 : cpol_0);
  // Derived from registers only, so it changes on the same edge as rx_cnt.
  assign last_clk = tip && rx_one;

  spi_bit_cnt #(.W(CNT_W)) u_tx_cnt (
    .clk      (wb_clk_in),
    .rst_n    (wb_rst_n),
    .load     (go_ok),
    .load_val ({1'b0, first_idx}),
    .dec      (tx_edge),
    .cnt      (tx_cnt),
    .zero     (tx_zero),
    .one      (unused_tx_one)
  );

  spi_bit_cnt #(.W(CNT_W)) u_rx_cnt (
    .clk      (wb_clk_in),
    .rst_n    (wb_rst_n),
    .load     (go_ok),
    .load_val (len_n),
    .dec      (rx_edge),
    .cnt      (rx_cnt),
    .zero     (rx_zero),
    .one      (rx_one)
  );

  always_ff @(posedge wb_clk_in) begin
    if (!wb_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    go_ok   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          go_ok   = 1'b1;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        // go is not looked at here, so a go on the final edge is dropped.
        if (rx_edge && rx_one) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_in) begin
    if (!wb_rst_n) begin
      mosi    <= 1'b0;
      rx_data <= '0;
      done    <= 1'b0;
      tx_reg  <= '0;
      len_q   <= '0;
      lsb_q   <= 1'b0;
    end else begin
      done <= finish;
      if (go_ok) begin
        tx_reg  <= tx_data;
        len_q   <= len;
        lsb_q   <= lsb;
        // First bit goes out with the load so it is valid before any sclk edge.
        mosi    <= lsb ? tx_data[0] : tx_data[first_idx];
        rx_data <= '0;
      end else begin
        if (tx_edge && !tx_zero) begin
          mosi <= tx_reg[tx_idx];
        end
        if (rx_edge && !rx_zero) begin
          rx_data[rx_idx] <= miso;
        end
        if (finish) begin
          mosi <= 1'b0;
        end
      end
    end
  end

endmodule
